// File: rtl/disp_pkg.sv
// Shared definitions for the multi-channel display scanner: mode encodings,
// default dwell width and the flattened-bus slicing helper.
package disp_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  localparam int DEF_DWELL_W = 16;

  // LSB position of channel ch in a bus built from back-to-back w-bit slices.
  function automatic int ch_base(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl.sv
// Channel sequencing for the display scanner: manual select or auto-scan with a
// programmable dwell, plus the channel-change strobe.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter  int CH      = 8,
  parameter  int DWELL_W = DEF_DWELL_W,
  localparam int SW      = $clog2(CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SW-1:0]      test,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SW-1:0]      next_ch,
  output logic               upd,
  output logic [SW-1:0]      cur_ch,
  output logic               ch_strobe
);

  logic               mode_q;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] nxt_cnt;
  logic [DWELL_W-1:0] eff_dwell;
  logic [SW-1:0]      nxt_ch;
  logic [SW-1:0]      wrap_ch;
  logic               test_ok;

  always_comb begin
    test_ok   = (int'(test) < CH);
    eff_dwell = (dwell == '0) ? DWELL_W'(1) : dwell;
    wrap_ch   = (cur_ch == SW'(CH - 1)) ? '0 : cur_ch + SW'(1);
    nxt_ch    = cur_ch;
    nxt_cnt   = cnt;
    upd       = 1'b0;
    if (en) begin
      if (mode == MODE_MANUAL) begin
        nxt_cnt = '0;
        // An out-of-range select leaves both the channel and the outputs alone.
        if (test_ok) begin
          nxt_ch = test;
          upd    = 1'b1;
        end
      end else begin
        upd = 1'b1;
        if (mode_q == MODE_MANUAL) begin
          nxt_cnt = '0;
          if (test_ok) nxt_ch = test;
        end else if (cnt >= eff_dwell - DWELL_W'(1)) begin
          nxt_cnt = '0;
          nxt_ch  = wrap_ch;
        end else begin
          nxt_cnt = cnt + DWELL_W'(1);
        end
      end
    end
    next_ch = nxt_ch;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_MANUAL;
      cnt       <= '0;
      cur_ch    <= '0;
      ch_strobe <= 1'b0;
    end else begin
      mode_q    <= mode;
      cnt       <= nxt_cnt;
      cur_ch    <= nxt_ch;
      ch_strobe <= en && (nxt_ch != cur_ch);
    end
  end

endmodule

// File: rtl/multi_nch_disp_scan.sv
// CH-channel display multiplexer with registered outputs, freeze enable and
// auto-scan; feeds the 7-segment display scanner.
module multi_nch_disp_scan
  import disp_pkg::*;
#(
  parameter  int CH      = 8,
  parameter  int DW      = 32,
  parameter  int DWELL_W = DEF_DWELL_W,
  localparam int PW      = DW / 4,
  localparam int SW      = $clog2(CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EN,
  input  logic                 mode,
  input  logic [SW-1:0]        Test,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [CH*PW-1:0]     point_in,
  input  logic [CH*PW-1:0]     LES,
  input  logic [CH*DW-1:0]     data_in,
  output logic [PW-1:0]        point_out,
  output logic [PW-1:0]        LE_out,
  output logic [DW-1:0]        Disp_num,
  output logic [SW-1:0]        cur_ch,
  output logic                 ch_strobe
);

  logic [SW-1:0] next_ch;
  logic          upd;
  logic [DW-1:0] data_p0;
  logic [PW-1:0] point_p0;
  logic [PW-1:0] le_p0;

  disp_scan_ctrl #(
    .CH      (CH),
    .DWELL_W (DWELL_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .en        (EN),
    .mode      (mode),
    .test      (Test),
    .dwell     (dwell),
    .next_ch   (next_ch),
    .upd       (upd),
    .cur_ch    (cur_ch),
    .ch_strobe (ch_strobe)
  );

  // Stage p0: select the channel the control block is moving to.
  always_comb begin
    data_p0  = '0;
    point_p0 = '0;
    le_p0    = '0;
    for (int k = 0; k < CH; k++) begin
      if (next_ch == SW'(k)) begin
        data_p0  = data_in[ch_base(k, DW) +: DW];
        point_p0 = point_in[ch_base(k, PW) +: PW];
        le_p0    = LES[ch_base(k, PW) +: PW];
      end
    end
  end

  // Stage p1: registered outputs, refreshed from live inputs on every update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Disp_num  <= '0;
      point_out <= '0;
      LE_out    <= '0;
    end else if (upd) begin
      Disp_num  <= data_p0;
      point_out <= point_p0;
      LE_out    <= le_p0;
    end
  end

endmodule

// File: tb/tb_multi_nch_disp_scan.sv
// Directed bench for multi_nch_disp_scan with CH=8, DW=32: channel k carries
// data 32'hkkkkkkkk, points 8'hk0 and LE 8'h0k.
module tb_multi_nch_disp_scan;

  localparam int CH = 8;
  localparam int DW = 32;
  localparam int PW = DW / 4;
  localparam int SW = 3;
  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               EN = 1'b0;
  logic               mode = 1'b0;
  logic [SW-1:0]      Test = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [CH*PW-1:0]   point_in = '0;
  logic [CH*PW-1:0]   LES = '0;
  logic [CH*DW-1:0]   data_in = '0;
  logic [PW-1:0]      point_out;
  logic [PW-1:0]      LE_out;
  logic [DW-1:0]      Disp_num;
  logic [SW-1:0]      cur_ch;
  logic               ch_strobe;

  int n_chk  = 0;
  int n_pass = 0;

  multi_nch_disp_scan #(
    .CH      (CH),
    .DW      (DW),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .mode      (mode),
    .Test      (Test),
    .dwell     (dwell),
    .point_in  (point_in),
    .LES       (LES),
    .data_in   (data_in),
    .point_out (point_out),
    .LE_out    (LE_out),
    .Disp_num  (Disp_num),
    .cur_ch    (cur_ch),
    .ch_strobe (ch_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tables();
    for (int k = 0; k < CH; k++) begin
      data_in[k*DW +: DW]  = 32'(32'h11111111 * k);
      point_in[k*PW +: PW] = 8'(k << 4);
      LES[k*PW +: PW]      = 8'(k);
    end
  endtask

  // Expected auto-scan trace from entry at channel 6 with dwell 4.
  logic [2:0] scan_ch [12] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7,
                               3'd0, 3'd0, 3'd0, 3'd0};
  logic       scan_sb [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] chan_data [8] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                 32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};

  initial begin
    // Reset held with random inputs.
    #2 rst = 1'b0;
    EN = 1'b1;
    mode = 1'($urandom_range(0, 1));
    Test = 3'($urandom_range(0, 7));
    dwell = 16'($urandom);
    for (int k = 0; k < CH*DW/32; k++) data_in[k*32 +: 32] = $urandom;
    point_in = {$urandom, $urandom};
    LES = {$urandom, $urandom};
    repeat (3) tick();
    check("rst_disp", Disp_num, 32'h0);
    check("rst_point", 32'(point_out), 32'h0);
    check("rst_le", 32'(LE_out), 32'h0);
    check("rst_cur", 32'(cur_ch), 32'h0);
    check("rst_strobe", 32'(ch_strobe), 32'h0);

    // Release in manual mode on channel 3.
    load_tables();
    EN = 1'b1; mode = 1'b0; Test = 3'd3; dwell = 16'd4;
    #2 rst = 1'b1;
    tick();
    check("first_disp", Disp_num, 32'h33333333);
    check("first_point", 32'(point_out), 32'h30);
    check("first_le", 32'(LE_out), 32'h03);
    check("first_strobe", 32'(ch_strobe), 32'h1);
    check("first_cur", 32'(cur_ch), 32'h3);
    tick();
    check("first_strobe_once", 32'(ch_strobe), 32'h0);

    // Manual sweep.
    for (int t = 0; t < CH; t++) begin
      Test = 3'(t);
      tick();
      check("sweep_disp", Disp_num, chan_data[t]);
      check("sweep_cur", 32'(cur_ch), 32'(t));
      repeat (9) tick();
    end

    // Freeze in manual mode.
    EN = 1'b0; Test = 3'd5;
    repeat (3) tick();
    check("frz_disp", Disp_num, 32'h77777777);
    check("frz_cur", 32'(cur_ch), 32'h7);
    check("frz_strobe", 32'(ch_strobe), 32'h0);

    // Live refresh on a held channel.
    EN = 1'b1;
    tick();
    check("live_sel", Disp_num, 32'h55555555);
    data_in[5*DW +: DW] = 32'hCAFEF00D;
    tick();
    check("live_refresh", Disp_num, 32'hCAFEF00D);
    check("live_nostrobe", 32'(ch_strobe), 32'h0);
    load_tables();
    tick();

    // Auto-scan from channel 6, dwell 4, wrapping 7 -> 0.
    mode = 1'b1; Test = 3'd6; dwell = 16'd4;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("scan_cur", 32'(cur_ch), 32'(scan_ch[i]));
      check("scan_strobe", 32'(ch_strobe), 32'(scan_sb[i]));
      check("scan_disp", Disp_num, chan_data[scan_ch[i]]);
    end

    // dwell = 0 advances every cycle.
    dwell = 16'd0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("dw0_cur", 32'(cur_ch), 32'(i));
      check("dw0_strobe", 32'(ch_strobe), 32'h1);
    end

    // Dwell shortened from 10 to 2 once cnt has reached 5.
    dwell = 16'd10;
    repeat (5) begin
      tick();
      check("dw10_cur", 32'(cur_ch), 32'h3);
    end
    dwell = 16'd2;
    tick();
    check("dwshrink_cur", 32'(cur_ch), 32'h4);
    check("dwshrink_strobe", 32'(ch_strobe), 32'h1);

    // Freeze mid-dwell in auto mode, then finish the remaining dwell.
    dwell = 16'd4;
    tick();
    EN = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("afrz_cur", 32'(cur_ch), 32'h4);
      check("afrz_strobe", 32'(ch_strobe), 32'h0);
    end
    EN = 1'b1;
    tick();
    check("resume1_cur", 32'(cur_ch), 32'h4);
    tick();
    check("resume2_cur", 32'(cur_ch), 32'h4);
    tick();
    check("resume3_cur", 32'(cur_ch), 32'h5);
    check("resume3_disp", Disp_num, 32'h55555555);

    // Asynchronous reset mid-cycle during auto-scan.
    #2 rst = 1'b0;
    #1;
    check("arst_disp", Disp_num, 32'h0);
    check("arst_point", 32'(point_out), 32'h0);
    check("arst_cur", 32'(cur_ch), 32'h0);
    mode = 1'b1; Test = 3'd2; EN = 1'b1; dwell = 16'd4;
    #1 rst = 1'b1;
    tick();
    check("rscan_cur", 32'(cur_ch), 32'h2);
    check("rscan_disp", Disp_num, 32'h22222222);
    check("rscan_strobe", 32'(ch_strobe), 32'h1);
    repeat (3) tick();
    check("rscan_hold", 32'(cur_ch), 32'h2);
    tick();
    check("rscan_adv", 32'(cur_ch), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
